sub_bytes_seq: RTL and testbench
================================

Name: sub_bytes_seq

Overview:
Sequential, parametrised AES/Rijndael SubBytes engine for the iterative cipher datapath.
- Accepts a 4 x NB byte state over a valid/ready handshake.
- Substitutes LANES bytes per cycle through LANES S-box lookups, trading area for latency.
- Returns the full substituted state over a second valid/ready handshake.
- Supports a runtime forward/inverse mode for a shared encrypt/decrypt round.

Parameters:
- NB, 4, number of state columns (4..8; 4 = AES).
- LANES, 4, S-box lookups per cycle; must divide 4*NB (1, 2, 4, 8, 16 for NB=4).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept a state.
- in_inv  in  1  mode for this state: 0 = forward S-box, 1 = inverse S-box.
- in_state  in  32*NB  byte [r][c] at bits [(r*NB+c)*8 +: 8].
- out_valid  out  1  out_state holds a completed result.
- out_ready  in  1  downstream accepts the result.
- out_state  out  32*NB  substituted state, same packing as in_state.
- busy  out  1  high in RUN or DONE.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Derived constant: N = 4*NB/LANES cycles per state.
- FSM states: IDLE, RUN, DONE.
- Reset values:
  - FSM = IDLE, byte index idx = 0, state buffer = 0, latched mode = 0.
  - out_valid = 0, busy = 0, in_ready = 1, out_state = 0.
- in_ready = (FSM == IDLE), combinational from the state register only. No other input feeds it.
- IDLE:
  - On in_valid && in_ready at an edge: buffer <= in_state, mode <= in_inv, idx <= 0, FSM -> RUN.
- RUN, each edge:
  - Bytes k = idx .. idx+LANES-1 (row-major, k = r*NB+c) are replaced by S(buffer[k]) or S^-1(buffer[k]), selected by the latched mode.
  - idx <= idx + LANES.
  - When idx + LANES == 4*NB: idx <= 0, FSM -> DONE.
  - S-box is a combinational 256-entry lookup per lane. No extra pipeline stage.
- Latency: acceptance at edge E0 gives out_valid = 1 after edge E0+N.
  - Default parameters: 4 cycles. LANES = 4*NB: 1 cycle.
- DONE:
  - out_valid = 1; out_state = buffer, held stable while out_ready = 0.
  - On out_ready: FSM -> IDLE, out_valid falls the next cycle. in_ready rises the same cycle.
- Throughput: one state per N+2 cycles at best. Input and output transfers never overlap.
- in_valid while not in IDLE: ignored, not sampled. Upstream holds it.
- in_inv and in_state changes during RUN/DONE: no effect (latched at acceptance).
- out_state is meaningful only while out_valid = 1. Between transfers it shows the partially substituted buffer.
- Reset asserted mid-RUN or in DONE:
  - Immediately FSM = IDLE, out_valid = 0, idx = 0, buffer cleared.
  - The in-flight state is discarded with no partial output.
- idx width: clog2(4*NB). It never exceeds 4*NB-LANES.

Optional Feature:
- Macro SUB_BYTES_INV_EN.
- Defined: inverse S-box table instantiated per lane; in_inv = 1 selects S^-1.
- Undefined:
  - No inverse table synthesised; latched mode is forced to 0.
  - in_inv is ignored and every state receives the forward S-box.
  - Port list is unchanged.

Test Plan:
- Reset then idle: out_valid = 0, in_ready = 1, busy = 0; hold in_valid = 0 for 10 cycles, and out_valid stays 0.
- Forward, NB=4, LANES=4: in_state bytes 19,3d,e3,be,a0,f4,e2,2b,9a,c6,8d,2a,e9,f8,48,08 -> out_valid after exactly 4 edges with d4,27,11,ae,e0,bf,98,f1,b8,b4,5d,e5,1e,41,52,30 in the same positions.
- Inverse with SUB_BYTES_INV_EN and in_inv = 1: all bytes 0x63 -> all 0x00; byte 0xed -> 0x53. Without the macro, the same stimulus yields all 0xfb and 0x55 (forward S-box).
- Backpressure: hold out_ready = 0 for 20 cycles in DONE -> out_state stable, in_ready = 0, new in_valid ignored; release -> one transfer, then in_ready = 1 next cycle.
- Parameter sweep: LANES = 1, 2, 8, 16 with all-0x00 input -> all 0x63 after 16, 8, 2, 1 edges respectively; NB=8, LANES=4 -> 32 bytes out after 8 edges.
- Reset mid-RUN at edge E0+2 -> out_valid never asserts; the next accepted state (all 0x53) returns all 0xed with normal latency.

Source files
------------

// File: rtl/sub_bytes_seq.sv
// Iterative AES/Rijndael SubBytes engine: LANES S-box lookups per cycle over a 4 x NB byte state.
// Optional inverse S-box via macro SUB_BYTES_INV_EN; without it every state uses the forward S-box.
module sub_bytes_seq #(
    parameter int unsigned NB    = 4,
    parameter int unsigned LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [32*NB-1:0] in_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_state,
    output logic             busy
);

    localparam int unsigned NBYTES = 4 * NB;
    localparam int unsigned W      = 8 * NBYTES;
    localparam int unsigned IDX_W  = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef SUB_BYTES_INV_EN
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     buffer;
    logic             mode;
    logic [7:0]       sub_c [LANES];
    logic             last_c;

    assign in_ready  = (state == IDLE);
    assign out_state = buffer;
    assign last_c    = (32'(idx) + LANES) == NBYTES;

`ifndef SUB_BYTES_INV_EN
    // Mode is pinned to forward; keep the mode path visibly terminated.
    logic unused_c;
    assign unused_c = in_inv ^ mode;
`endif

    // One S-box lookup per lane on the current window of the buffer.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
`ifdef SUB_BYTES_INV_EN
            sub_c[l] = mode ? INV_SBOX[buffer[(32'(idx) + l) * 8 +: 8]]
                            : FWD_SBOX[buffer[(32'(idx) + l) * 8 +: 8]];
`else
            sub_c[l] = FWD_SBOX[buffer[(32'(idx) + l) * 8 +: 8]];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            buffer    <= '0;
            mode      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        buffer <= in_state;
`ifdef SUB_BYTES_INV_EN
                        mode   <= in_inv;
`else
                        mode   <= 1'b0;
`endif
                        idx    <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        buffer[(32'(idx) + l) * 8 +: 8] <= sub_c[l];
                    end
                    if (last_c) begin
                        idx       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(LANES);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: FIPS-197 SubBytes vector, mode, backpressure, lane sweep, reset.
module tb_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_inv = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_state = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_state;

    logic         sw_valid = 1'b0;
    logic         sw_inv = 1'b0;
    logic         sw_ready = 1'b1;
    logic [255:0] sw_state = '0;
    logic         s_ready [5];
    logic         s_valid [5];
    logic         s_busy  [5];
    logic [127:0] s1_out, s2_out, s8_out, s16_out;
    logic [255:0] n8_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sub_bytes_seq #(.NB(4), .LANES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy)
    );

    sub_bytes_seq #(.NB(4), .LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ready[0]), .in_inv(sw_inv),
        .in_state(sw_state[127:0]), .out_valid(s_valid[0]), .out_ready(sw_ready),
        .out_state(s1_out), .busy(s_busy[0])
    );
    sub_bytes_seq #(.NB(4), .LANES(2)) u_l2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ready[1]), .in_inv(sw_inv),
        .in_state(sw_state[127:0]), .out_valid(s_valid[1]), .out_ready(sw_ready),
        .out_state(s2_out), .busy(s_busy[1])
    );
    sub_bytes_seq #(.NB(4), .LANES(8)) u_l8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ready[2]), .in_inv(sw_inv),
        .in_state(sw_state[127:0]), .out_valid(s_valid[2]), .out_ready(sw_ready),
        .out_state(s8_out), .busy(s_busy[2])
    );
    sub_bytes_seq #(.NB(4), .LANES(16)) u_l16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ready[3]), .in_inv(sw_inv),
        .in_state(sw_state[127:0]), .out_valid(s_valid[3]), .out_ready(sw_ready),
        .out_state(s16_out), .busy(s_busy[3])
    );
    sub_bytes_seq #(.NB(8), .LANES(4)) u_nb8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ready[4]), .in_inv(sw_inv),
        .in_state(sw_state), .out_valid(s_valid[4]), .out_ready(sw_ready),
        .out_state(n8_out), .busy(s_busy[4])
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [7:0] b, input int nbytes);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < nbytes; k++) v[k*8 +: 8] = b;
        return v;
    endfunction

    // Present one state, scramble the inputs after acceptance, and count edges to out_valid.
    task automatic send_main(input logic [127:0] st, input logic inv,
                             output int lat, output logic [127:0] res);
        @(negedge clk);
        in_state = st;
        in_inv   = inv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_state = ~st;
        in_inv   = ~inv;
        lat = 0;
        res = '0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                res = out_state;
            end
        end
    endtask

    task automatic after_transfer(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready"}, 256'(in_ready), 256'(1'b1));
        check({tag, "_valid"}, 256'(out_valid), 256'(1'b0));
    endtask

    logic [7:0]   fin  [16] = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                                8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
    logic [7:0]   fexp [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                                8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};

    initial begin
        int           lat;
        logic [127:0] res;
        logic [127:0] st, ex;
        logic [255:0] tmp, tmp2;
        logic         seen;
        int           lat_sw [5];
        logic [255:0] res_sw [5];
        int           exp_lat [5] = '{16, 8, 2, 1, 8};

        repeat (2) @(negedge clk);
        check("rst_out_valid", 256'(out_valid), 256'(1'b0));
        check("rst_in_ready", 256'(in_ready), 256'(1'b1));
        check("rst_busy", 256'(busy), 256'(1'b0));
        check("rst_out_state", 256'(out_state), 256'(0));
        for (int i = 0; i < 5; i++) begin
            check("sw_rst_ready", 256'(s_ready[i]), 256'(1'b1));
            check("sw_rst_busy", 256'(s_busy[i]), 256'(1'b0));
        end
        rst = 1'b0;

        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("idle_no_valid", 256'(seen), 256'(1'b0));

        // FIPS-197 round-1 SubBytes vector
        for (int k = 0; k < 16; k++) begin
            st[k*8 +: 8] = fin[k];
            ex[k*8 +: 8] = fexp[k];
        end
        send_main(st, 1'b0, lat, res);
        check("fwd_latency", 256'(lat), 256'(4));
        check("fwd_state", 256'(res), 256'(ex));
        check("done_busy", 256'(busy), 256'(1'b1));
        check("done_in_ready", 256'(in_ready), 256'(1'b0));
        after_transfer("fwd_post");

        tmp = fill(8'h63, 16);
        send_main(tmp[127:0], 1'b1, lat, res);
`ifdef SUB_BYTES_INV_EN
        tmp2 = fill(8'h00, 16);
`else
        tmp2 = fill(8'hfb, 16);
`endif
        check("inv_latency", 256'(lat), 256'(4));
        check("inv_all63", 256'(res), tmp2);
        after_transfer("inv_post");

        tmp = fill(8'h63, 16);
        tmp[7:0] = 8'hed;
`ifdef SUB_BYTES_INV_EN
        tmp2 = fill(8'h00, 16);
        tmp2[7:0] = 8'h53;
`else
        tmp2 = fill(8'hfb, 16);
        tmp2[7:0] = 8'h55;
`endif
        send_main(tmp[127:0], 1'b1, lat, res);
        check("inv_mixed", 256'(res), tmp2);
        after_transfer("mix_post");

        tmp = fill(8'h00, 16);
        send_main(tmp[127:0], 1'b0, lat, res);
        check("fwd_zero", 256'(res), fill(8'h63, 16));
        after_transfer("zero_post");

        // Backpressure: result held while a new state is offered and must be ignored
        out_ready = 1'b0;
        tmp = fill(8'h53, 16);
        send_main(tmp[127:0], 1'b0, lat, res);
        check("bp_latency", 256'(lat), 256'(4));
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_state = 128'h0123456789abcdef0123456789abcdef;
            check("bp_valid", 256'(out_valid), 256'(1'b1));
            check("bp_state", 256'(out_state), fill(8'hed, 16));
            check("bp_in_ready", 256'(in_ready), 256'(1'b0));
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_hold_state", 256'(out_state), fill(8'hed, 16));
        after_transfer("bp_release");
        @(posedge clk);
        @(negedge clk);
        check("bp_single_xfer", 256'(out_valid), 256'(1'b0));
        check("bp_idle_busy", 256'(busy), 256'(1'b0));

        // Lane / column sweep on an all-zero state
        for (int i = 0; i < 5; i++) begin
            lat_sw[i] = 0;
            res_sw[i] = '0;
        end
        sw_state = '0;
        sw_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sw_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (s_valid[0] && lat_sw[0] == 0) begin lat_sw[0] = n; res_sw[0] = 256'(s1_out);  end
            if (s_valid[1] && lat_sw[1] == 0) begin lat_sw[1] = n; res_sw[1] = 256'(s2_out);  end
            if (s_valid[2] && lat_sw[2] == 0) begin lat_sw[2] = n; res_sw[2] = 256'(s8_out);  end
            if (s_valid[3] && lat_sw[3] == 0) begin lat_sw[3] = n; res_sw[3] = 256'(s16_out); end
            if (s_valid[4] && lat_sw[4] == 0) begin lat_sw[4] = n; res_sw[4] = n8_out;        end
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("sweep%0d_latency", i), 256'(lat_sw[i]), 256'(exp_lat[i]));
            check($sformatf("sweep%0d_state", i), res_sw[i], fill(8'h63, (i == 4) ? 32 : 16));
        end

        // Reset in the middle of a run discards the state
        @(negedge clk);
        in_state = '0;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mrst_valid", 256'(out_valid), 256'(1'b0));
        check("mrst_busy", 256'(busy), 256'(1'b0));
        check("mrst_in_ready", 256'(in_ready), 256'(1'b1));
        check("mrst_buffer", 256'(out_state), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mrst_no_output", 256'(seen), 256'(1'b0));
        tmp = fill(8'h53, 16);
        send_main(tmp[127:0], 1'b0, lat, res);
        check("mrst_next_latency", 256'(lat), 256'(4));
        check("mrst_next_state", 256'(res), fill(8'hed, 16));
        after_transfer("mrst_post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
